// File: rtl/pwm_pkg.sv
// pwm_pkg: shared parameter defaults, channel index width helper and mode encoding for pwm_bank.
package pwm_pkg;
  localparam int NCH_DEF        = 4;
  localparam int WIDTH_DEF      = 8;
  localparam int PERIOD_RST_DEF = 250;
  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one channel's staging/active duty pair and registered compare against the shared count.
module pwm_chan import pwm_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_duty_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             pwm_o
);
  logic [WIDTH-1:0] duty_stg_q, duty_stg_d, duty_act_q, duty_act_d;
  logic             pwm_q, pwm_d;
  always_comb begin
    duty_stg_d = wr_en_i ? wr_duty_i : duty_stg_q;
    duty_act_d = load_i ? duty_stg_q : duty_act_q;
    pwm_d      = count_i < duty_act_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      duty_stg_q <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_stg_q <= duty_stg_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end
  assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: NCH-channel PWM with a shared counter; duties and period update only at period boundaries.
// Define PWM_BANK_CENTER_EN to add mode_i and center-aligned counting.
module pwm_bank import pwm_pkg::*; #(
  parameter int NCH        = NCH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PERIOD_RST = PERIOD_RST_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tp_i,
  input  logic [WIDTH-1:0]      period_i,
  input  logic                  period_valid_i,
  input  logic                  wr_valid_i,
  input  logic [idx_w(NCH)-1:0] wr_ch_i,
  input  logic [WIDTH-1:0]      wr_duty_i,
`ifdef PWM_BANK_CENTER_EN
  input  logic                  mode_i,
`endif
  output logic [NCH-1:0]        pwm_o,
  output logic                  period_end_o,
  output logic [WIDTH-1:0]      count_o
);
  localparam int IW = idx_w(NCH);
  localparam logic [WIDTH-1:0] PER_RST = WIDTH'(PERIOD_RST);
  logic [WIDTH-1:0] count_q, count_d, period_stg_q, period_stg_d, period_act_q, period_act_d;
  logic             period_end_q, period_end_d, boundary;
`ifdef PWM_BANK_CENTER_EN
  mode_e mode_q, mode_d;
  logic  dir_q, dir_d;
  // A zero period degenerates to edge behaviour so count stays pinned at 0.
  always_comb begin
    count_d  = count_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (tp_i) begin
      if (mode_q == MODE_EDGE || period_act_q == '0) begin
        boundary = count_q >= period_act_q;
        count_d  = boundary ? '0 : count_q + 1'b1;
        dir_d    = 1'b0;
      end else if (dir_q || count_q >= period_act_q) begin
        count_d  = count_q - 1'b1;
        boundary = count_d == '0;
        dir_d    = !boundary;
      end else begin
        count_d  = count_q + 1'b1;
      end
    end
    mode_d = boundary ? mode_e'(mode_i) : mode_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= MODE_EDGE;
      dir_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
    end
  end
`else
  always_comb begin
    boundary = tp_i && count_q >= period_act_q;
    count_d  = boundary ? '0 : tp_i ? count_q + 1'b1 : count_q;
  end
`endif
  always_comb begin
    period_stg_d = period_valid_i ? period_i : period_stg_q;
    period_act_d = boundary ? period_stg_q : period_act_q;
    period_end_d = boundary;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= '0;
      period_stg_q <= PER_RST;
      period_act_q <= PER_RST;
      period_end_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      period_stg_q <= period_stg_d;
      period_act_q <= period_act_d;
      period_end_q <= period_end_d;
    end
  end
  // Indices >= NCH match no channel, so such writes fall away.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pwm_chan #(.WIDTH(WIDTH)) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (wr_valid_i && wr_ch_i == IW'(c)),
      .wr_duty_i (wr_duty_i),
      .load_i    (boundary),
      .count_i   (count_q),
      .pwm_o     (pwm_o[c])
    );
  end
  assign period_end_o = period_end_q;
  assign count_o      = count_q;
endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 The block SHALL have parameter NCH, default 4: number of PWM channels, range 1..16.
REQ-002 The block SHALL have parameter WIDTH, default 8: counter, period and duty width in bits.
REQ-003 The block SHALL have parameter PERIOD_RST, default 250: period register value after reset.
REQ-004 The block SHALL have port clk_i, input, width 1: the single clock, with all state on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port tp_i, input, width 1: timepulse, a one-cycle tick; the counter advances only when it is high.
REQ-007 The block SHALL have port period_i, input, width WIDTH: new period value.
REQ-008 The block SHALL have port period_valid_i, input, width 1: staging strobe for period_i.
REQ-009 The block SHALL have ports wr_valid_i (input, 1), wr_ch_i (input, max(1,clog2(NCH))) and wr_duty_i (input, WIDTH): the duty write strobe, channel index and duty value.
REQ-010 The block SHALL have port pwm_o, input-independent output, width NCH: the PWM outputs, bit c belonging to channel c.
REQ-011 The block SHALL have port period_end_o, output, width 1: one-cycle strobe on each period boundary.
REQ-012 The block SHALL have port count_o, output, width WIDTH: current counter value.

Function
REQ-013 A write with wr_valid_i high SHALL update the staging duty of channel wr_ch_i on the next edge; a write with wr_ch_i >= NCH SHALL be ignored.
REQ-014 With period_valid_i high, period_i SHALL be captured into the staging period on the next edge.
REQ-015 Edge mode: on a tp_i high cycle, count SHALL increment, and wrap from count == active period to 0.
REQ-016 The period boundary SHALL be the tp_i cycle in which count wraps (edge mode) or turns from down to up at 0 (center mode).
REQ-017 On the boundary edge, all active duties and the active period SHALL load from staging simultaneously, and period_end_o SHALL be high for exactly that following cycle.
REQ-018 A staging write in the same cycle as a boundary SHALL NOT be loaded at that boundary; it takes effect at the next boundary.
REQ-019 pwm_o[c] SHALL equal (count < active_duty[c]), registered, with one clk_i cycle latency from count.
REQ-020 Boundary values: duty 0 SHALL give constant low; duty > active period SHALL give constant high.
REQ-021 An active period of 0 SHALL hold count at 0, assert period_end_o on every tp_i, and still allow the boundary load.
REQ-022 When tp_i is low, count, the outputs and the active registers SHALL hold; staging writes SHALL still be accepted.
REQ-023 If a boundary loads an active period smaller than count, count SHALL wrap to 0 on the next tp_i (edge mode) or start counting down (center mode).

Reset
REQ-024 While rst_ni is low, the block SHALL immediately hold: count = 0, direction = up, staging and active period = PERIOD_RST, all staging and active duties = 0, pwm_o = 0, period_end_o = 0.
REQ-025 Reset asserted mid-period SHALL abort the period with no boundary strobe; after release, counting SHALL resume from 0 on the first tp_i.

Configuration
REQ-026 With macro PWM_BANK_CENTER_EN defined, the block SHALL add input mode_i (1 bit, 1 = center-aligned), sampled only at boundaries.
REQ-027 In center-aligned mode, count SHALL go 0 up to period then down to 0, with direction reversing at each end, giving a period of 2*period tp_i ticks.
REQ-028 Without PWM_BANK_CENTER_EN, the block SHALL have no mode_i port and no direction register, and SHALL be edge-aligned only.

Structure
REQ-029 The parameter defaults, the max(1,clog2(NCH)) index-width function and the mode encoding SHALL live in package pwm_pkg.
REQ-030 The per-channel staging/active duty registers and comparator SHALL be sub-module pwm_chan, instantiated NCH times by a generate loop; the shared counter and boundary logic SHALL live in pwm_bank.

Verification
REQ-031 Scenario: reset, then tp_i every cycle, period 9, duty ch0 = 3 -> pwm_o[0] is high 3 of every 10 ticks, and period_end_o fires every 10 ticks.
REQ-032 Scenario: write duty ch1 = 5 mid-period -> pwm_o[1] stays unchanged until period_end_o, then runs at 5/10.
REQ-033 Scenario: wr_valid_i in the same cycle as the boundary, with ch0 = 7 -> the old duty is applied for one more period, then 7.
REQ-034 Scenario: duty 0 -> always low; duty 12 with period 9 -> always high; wr_ch_i = NCH -> no register changes.
REQ-035 Scenario: rst_ni pulsed low at count 6 -> all outputs are 0 at once, and count restarts at 0 with period 250.
REQ-036 Scenario: PWM_BANK_CENTER_EN defined, mode_i = 1, period 4, duty 2 -> count sequence 0,1,2,3,4,3,2,1,0 and pwm_o is symmetric about count 4.
